// File: rtl/onchip_ram_dp_pipe_if.sv
// ---------------------------------------------------------------------------
// onchip_ram_dp_pipe_if
// Avalon-MM style slave bus for one port of the dual-port on-chip RAM.
//
// Signals
//   address        word address (ADDR_WIDTH)
//   chipselect     port select
//   read / write   command strobes; a write wins if both are raised together
//   byteenable     byte lanes to update on a write (DATA_WIDTH/8)
//   writedata      write data
//   readdata       read data, qualified by readdatavalid
//   readdatavalid  one pulse per returned read beat
//   waitrequest    stall; no command is accepted while it is high
//
// Modports
//   master : drives the command, receives the response (processor side)
//   slave  : receives the command, drives the response (RAM side)
// ---------------------------------------------------------------------------
interface onchip_ram_dp_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_ram_dp_pipe.sv
// ---------------------------------------------------------------------------
// onchip_ram_dp_pipe
// Dual-port on-chip RAM shared by two processor cores. Each port is an
// independent Avalon-MM slave with pipelined reads (latency 1 or 2) and
// byte-enabled writes. A clear engine can fill the whole array with
// CLEAR_VALUE, stalling both ports while it runs.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset (released synchronously inside)
//   clken_i       global clock enable; low freezes the read pipeline and
//                 blocks command accepts
//   s1, s2        slave bus ports (see onchip_ram_dp_pipe_if)
//   clear_req_i   one-cycle pulse that starts the clear engine
//   clear_busy_o  high while the clear engine owns the array
//   oob_err_o     sticky flag: some port accessed an address >= DEPTH
// ---------------------------------------------------------------------------
module onchip_ram_dp_pipe #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 17,
    parameter int                    DEPTH        = 75000,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
    parameter string                 INIT_FILE    = "onchip_ram.hex"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken_i,
    onchip_ram_dp_pipe_if.slave  s1,
    onchip_ram_dp_pipe_if.slave  s2,
    input  logic                 clear_req_i,
    output logic                 clear_busy_o,
    output logic                 oob_err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAIN
    } clr_state_e;

    // Power-up contents come from INIT_FILE through the vendor RAM init
    // attribute; reset never touches the array.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Reset is asserted asynchronously but released two clocks later so
    // every register leaves reset on the same edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Per-port views of the two buses so the rest of the logic can loop.
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [BYTES-1:0]      be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [IDX_W-1:0]      idx   [2];
    logic [1:0]            cs, rd, wr;
    logic [1:0]            accept, wr_acc, rd_acc, oob;
    logic                  waitreq;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read,       s1.read};
    assign wr       = {s2.write,      s1.write};

    assign waitreq  = clear_busy_o | ~clken_i;

    // A simultaneous read+write is treated as a write; the read is dropped.
    for (genvar p = 0; p < 2; p++) begin : g_port
        assign accept[p] = cs[p] & (rd[p] | wr[p]) & ~waitreq & clken_i;
        assign wr_acc[p] = accept[p] & wr[p];
        assign rd_acc[p] = accept[p] & rd[p] & ~wr[p];
        assign oob[p]    = {1'b0, addr[p]} >= DEPTH_W;
        assign idx[p]    = addr[p][IDX_W-1:0];
    end

    // Clear engine state register and address counter.
    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             clr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear engine next state. It writes one word per enabled cycle and
    // then spends one DRAIN cycle so reads already in the pipeline when the
    // clear began leave with pre-clear data before the ports reopen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clken_i) begin
                    clr_we = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (clken_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clear_busy_o = (state_q != ST_IDLE);

    // Array writes. Port 2 is applied before port 1 so that on a same-address
    // collision port 1's lanes overwrite port 2's, while lanes only port 2
    // enables still land. The clear engine runs only while both ports stall.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= CLEAR_VALUE;
        end else begin
            for (int p = 1; p >= 0; p--) begin
                if (wr_acc[p] && !oob[p]) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (be[p][b]) begin
                            mem_q[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // First read stage. Sampling the array with a non-blocking read means a
    // same-cycle write from the other port is not yet visible: old data.
    // Out-of-bounds reads return zero with normal timing.
    logic [DATA_WIDTH-1:0] rdata1_q [2];
    logic [1:0]            rvalid1_q;
    logic [DATA_WIDTH-1:0] out_data [2];
    logic [1:0]            out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid1_q <= '0;
            for (int p = 0; p < 2; p++) begin
                rdata1_q[p] <= '0;
            end
        end else if (clken_i) begin
            rvalid1_q <= rd_acc;
            for (int p = 0; p < 2; p++) begin
                if (rd_acc[p]) begin
                    rdata1_q[p] <= oob[p] ? '0 : mem_q[idx[p]];
                end
            end
        end
    end

    // Optional output register for the two-cycle read latency.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rdata2_q [2];
        logic [1:0]            rvalid2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid2_q <= '0;
                for (int p = 0; p < 2; p++) begin
                    rdata2_q[p] <= '0;
                end
            end else if (clken_i) begin
                rvalid2_q <= rvalid1_q;
                for (int p = 0; p < 2; p++) begin
                    rdata2_q[p] <= rdata1_q[p];
                end
            end
        end

        assign out_data[0] = rdata2_q[0];
        assign out_data[1] = rdata2_q[1];
        assign out_valid   = rvalid2_q;
    end else begin : g_lat1
        assign out_data[0] = rdata1_q[0];
        assign out_data[1] = rdata1_q[1];
        assign out_valid   = rvalid1_q;
    end

    // A beat parked in the pipeline during a clken stall is presented only
    // once clken returns, so valid is gated by clken.
    assign s1.readdata      = out_data[0];
    assign s2.readdata      = out_data[1];
    assign s1.readdatavalid = out_valid[0] & clken_i;
    assign s2.readdatavalid = out_valid[1] & clken_i;
    assign s1.waitrequest   = waitreq;
    assign s2.waitrequest   = waitreq;

    // Sticky out-of-bounds flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err_o <= 1'b0;
        end else if (|(accept & oob)) begin
            oob_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_onchip_ram_dp_pipe.sv
// ---------------------------------------------------------------------------
// tb_onchip_ram_dp_pipe
// Drives two copies of the RAM (read latency 1 and 2, DEPTH 16) with the
// same commands so both hold identical contents; only the read timing of
// the two copies differs.
// ---------------------------------------------------------------------------
module tb_onchip_ram_dp_pipe;

    typedef struct packed {
        logic [7:0]  addr;
        logic        cs;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wd;
    } cmd_t;

    typedef struct {
        cmd_t        c1;
        cmd_t        c2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    localparam cmd_t NOP = '0;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic clken = 1'b1;
    logic clearReq = 1'b0;
    cmd_t p1Cmd = '0;
    cmd_t p2Cmd = '0;
    logic clearBusyA, clearBusyB, oobErrA, oobErrB;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    onchip_ram_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) sA1();
    onchip_ram_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) sA2();
    onchip_ram_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) sB1();
    onchip_ram_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) sB2();

    assign {sA1.address, sA1.chipselect, sA1.read, sA1.write, sA1.byteenable, sA1.writedata} = p1Cmd;
    assign {sA2.address, sA2.chipselect, sA2.read, sA2.write, sA2.byteenable, sA2.writedata} = p2Cmd;
    assign {sB1.address, sB1.chipselect, sB1.read, sB1.write, sB1.byteenable, sB1.writedata} = p1Cmd;
    assign {sB2.address, sB2.chipselect, sB2.read, sB2.write, sB2.byteenable, sB2.writedata} = p2Cmd;

    onchip_ram_dp_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .READ_LATENCY(1),
        .CLEAR_VALUE(32'hA5A5A5A5), .INIT_FILE("")
    ) dutA (
        .clk(clk), .reset_n(resetN), .clken_i(clken),
        .s1(sA1), .s2(sA2),
        .clear_req_i(clearReq), .clear_busy_o(clearBusyA), .oob_err_o(oobErrA)
    );

    onchip_ram_dp_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .READ_LATENCY(2),
        .CLEAR_VALUE(32'hA5A5A5A5), .INIT_FILE("")
    ) dutB (
        .clk(clk), .reset_n(resetN), .clken_i(clken),
        .s1(sB1), .s2(sB2),
        .clear_req_i(clearReq), .clear_busy_o(clearBusyB), .oob_err_o(oobErrB)
    );

    function automatic cmd_t rdCmd(input logic [7:0] a);
        cmd_t c = '0;
        c.addr = a; c.cs = 1'b1; c.rd = 1'b1;
        return c;
    endfunction

    function automatic cmd_t wrCmd(input logic [7:0] a, input logic [3:0] be, input logic [31:0] wd);
        cmd_t c = '0;
        c.addr = a; c.cs = 1'b1; c.wr = 1'b1; c.be = be; c.wd = wd;
        return c;
    endfunction

    task automatic applyStimulus(input cmd_t c1, input cmd_t c2);
        p1Cmd = c1;
        p2Cmd = c2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One command cycle, then check latency-1 copy one cycle later and the
    // latency-2 copy two cycles later.
    task automatic runVector(input vec_t v, input string tag);
        logic e1, e2;
        e1 = v.c1.rd & ~v.c1.wr;
        e2 = v.c2.rd & ~v.c2.wr;
        @(negedge clk);
        applyStimulus(v.c1, v.c2);
        @(negedge clk);
        applyStimulus(NOP, NOP);
        #1;
        checkOutput({tag, ".A.s1.valid"}, 32'(sA1.readdatavalid), 32'(e1));
        checkOutput({tag, ".A.s2.valid"}, 32'(sA2.readdatavalid), 32'(e2));
        if (e1) checkOutput({tag, ".A.s1.data"}, sA1.readdata, v.exp1);
        if (e2) checkOutput({tag, ".A.s2.data"}, sA2.readdata, v.exp2);
        @(negedge clk);
        #1;
        checkOutput({tag, ".A.s1.idle"}, 32'(sA1.readdatavalid), 32'd0);
        checkOutput({tag, ".B.s1.valid"}, 32'(sB1.readdatavalid), 32'(e1));
        checkOutput({tag, ".B.s2.valid"}, 32'(sB2.readdatavalid), 32'(e2));
        if (e1) checkOutput({tag, ".B.s1.data"}, sB1.readdata, v.exp1);
        if (e2) checkOutput({tag, ".B.s2.data"}, sB2.readdata, v.exp2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[14];
        vec_t oobVecs[3];
        int   aIdx[8] = '{-1, 0, -1, -1, 1, 2, 3, -1};
        int   bIdx[8] = '{-1, -1, -1, -1, 0, 1, 2, 3};
        int   busyCycles;
        int   cyc;
        bit   done;

        vecs[0]  = '{wrCmd(5, 4'hF, 32'hDEADBEEF), NOP, 32'h0, 32'h0};
        vecs[1]  = '{rdCmd(5), NOP, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{wrCmd(7, 4'hF, 32'h11223344), NOP, 32'h0, 32'h0};
        vecs[3]  = '{NOP, wrCmd(7, 4'h5, 32'hAABBCCDD), 32'h0, 32'h0};
        vecs[4]  = '{NOP, rdCmd(7), 32'h0, 32'h11BB33DD};
        vecs[5]  = '{wrCmd(9, 4'h1, 32'h000000FF), wrCmd(9, 4'hF, 32'hFFFFFF00), 32'h0, 32'h0};
        vecs[6]  = '{rdCmd(9), wrCmd(9, 4'hF, 32'h12345678), 32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{rdCmd(7), rdCmd(9), 32'h11BB33DD, 32'h12345678};
        vecs[8]  = '{wrCmd(3, 4'hF, 32'h01020304), NOP, 32'h0, 32'h0};
        vecs[9]  = '{wrCmd(3, 4'h0, 32'hFFFFFFFF), NOP, 32'h0, 32'h0};
        vecs[10] = '{NOP, rdCmd(3), 32'h0, 32'h01020304};
        vecs[11] = '{wrCmd(10, 4'hF, 32'h00000000), NOP, 32'h0, 32'h0};
        vecs[12] = '{wrCmd(10, 4'hC, 32'hAAAAAAAA), wrCmd(10, 4'h6, 32'h55555555), 32'h0, 32'h0};
        vecs[13] = '{rdCmd(10), rdCmd(10), 32'hAAAA5500, 32'hAAAA5500};

        oobVecs[0] = '{wrCmd(4, 4'hF, 32'h44444444), NOP, 32'h0, 32'h0};
        oobVecs[1] = '{wrCmd(20, 4'hF, 32'h00000001), NOP, 32'h0, 32'h0};
        oobVecs[2] = '{rdCmd(20), rdCmd(4), 32'h0, 32'h44444444};

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst.A.valid", 32'({sA1.readdatavalid, sA2.readdatavalid}), 32'd0);
        checkOutput("rst.B.valid", 32'({sB1.readdatavalid, sB2.readdatavalid}), 32'd0);
        checkOutput("rst.A.rdata", sA1.readdata, 32'h0);
        checkOutput("rst.B.rdata", sB2.readdata, 32'h0);
        checkOutput("rst.busy", 32'({clearBusyA, clearBusyB}), 32'd0);
        checkOutput("rst.oob", 32'({oobErrA, oobErrB}), 32'd0);
        checkOutput("rst.waitreq", 32'({sA1.waitrequest, sA2.waitrequest, sB1.waitrequest}), 32'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < 14; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] streaming with clken stall");
        runVector('{wrCmd(12, 4'hF, 32'hC0DE000C), wrCmd(13, 4'hF, 32'hC0DE000D), 32'h0, 32'h0}, "strm.w0");
        runVector('{wrCmd(14, 4'hF, 32'hC0DE000E), wrCmd(15, 4'hF, 32'hC0DE000F), 32'h0, 32'h0}, "strm.w1");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clken = !(k == 2 || k == 3);
            case (k)
                0:       applyStimulus(rdCmd(12), NOP);
                1:       applyStimulus(rdCmd(13), NOP);
                2, 3, 4: applyStimulus(rdCmd(14), NOP);
                5:       applyStimulus(rdCmd(15), NOP);
                default: applyStimulus(NOP, NOP);
            endcase
            #1;
            checkOutput($sformatf("strm%0d.waitreq", k), 32'(sA1.waitrequest), 32'(k == 2 || k == 3));
            checkOutput($sformatf("strm%0d.A.valid", k), 32'(sA1.readdatavalid), 32'(aIdx[k] >= 0));
            checkOutput($sformatf("strm%0d.B.valid", k), 32'(sB1.readdatavalid), 32'(bIdx[k] >= 0));
            if (aIdx[k] >= 0) checkOutput($sformatf("strm%0d.A.data", k), sA1.readdata, 32'hC0DE000C + 32'(aIdx[k]));
            if (bIdx[k] >= 0) checkOutput($sformatf("strm%0d.B.data", k), sB1.readdata, 32'hC0DE000C + 32'(bIdx[k]));
        end

        $display("[TB] out of bounds");
        checkOutput("oob.before", 32'({oobErrA, oobErrB}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            runVector(oobVecs[i], $sformatf("oob%0d", i));
        end
        checkOutput("oob.set", 32'({oobErrA, oobErrB}), 32'b11);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("oob.held", 32'({oobErrA, oobErrB}), 32'b11);

        $display("[TB] clear engine");
        @(negedge clk);
        applyStimulus(rdCmd(5), NOP);
        @(negedge clk);
        applyStimulus(NOP, rdCmd(7));
        clearReq = 1'b1;
        #1;
        checkOutput("clr.busy_at_req", 32'({clearBusyA, clearBusyB}), 32'd0);
        checkOutput("clr.pre.A.s1", {31'd0, sA1.readdatavalid} == 32'd1 ? sA1.readdata : 32'hBAD0BAD0, 32'hDEADBEEF);
        @(negedge clk);
        applyStimulus(NOP, NOP);
        clearReq = 1'b0;
        #1;
        checkOutput("clr.same.A.s2", sA2.readdatavalid ? sA2.readdata : 32'hBAD0BAD0, 32'h11BB33DD);
        checkOutput("clr.pre.B.s1", sB1.readdatavalid ? sB1.readdata : 32'hBAD0BAD0, 32'hDEADBEEF);
        busyCycles = 0;
        cyc = 2;
        done = 1'b0;
        while (!done && cyc < 60) begin
            if (cyc == 3) begin
                checkOutput("clr.same.B.s2", sB2.readdatavalid ? sB2.readdata : 32'hBAD0BAD0, 32'h11BB33DD);
            end
            if (clearBusyA) begin
                busyCycles++;
                checkOutput($sformatf("clr%0d.waitreq", cyc),
                            32'({sA1.waitrequest, sA2.waitrequest, sB1.waitrequest, sB2.waitrequest, clearBusyB}),
                            32'h1F);
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput("clr.busy_cycles", 32'(busyCycles), 32'd17);
        checkOutput("clr.waitreq_after", 32'({sA1.waitrequest, sB2.waitrequest}), 32'd0);
        for (int i = 0; i < 16; i++) begin
            runVector('{rdCmd(8'(i)), rdCmd(8'(15 - i)), 32'hA5A5A5A5, 32'hA5A5A5A5},
                      $sformatf("clr.rd%0d", i));
        end

        $display("[TB] reset pulse");
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("rst2.oob", 32'({oobErrA, oobErrB}), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst2.oob_after", 32'({oobErrA, oobErrB}), 32'd0);
        runVector('{rdCmd(9), NOP, 32'hA5A5A5A5, 32'h0}, "rst2.mem_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/onchip_ram_dp_pipe.md
Name: onchip_ram_dp_pipe

Overview:
Parametrised dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2), so two processor cores can share one image/data buffer. Reads are pipelined with a configurable latency of 1 or 2 cycles and flagged by readdatavalid. Byte-enabled writes are supported, and cross-port collisions resolve deterministically. A built-in clear engine fills the whole array with a constant on request, with waitrequest back-pressure on both ports while it runs.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 17, word-address width on both ports.
DEPTH, 75000, number of words; DEPTH <= 2**ADDR_WIDTH.
READ_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
CLEAR_VALUE, 0, word written to every location by the clear engine.
INIT_FILE, "onchip_ram.hex", power-up contents (simulation/synthesis init only; not reapplied on reset).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clken  in  1  global clock enable; 0 freezes the read pipeline and blocks accepts
s1_address  in  ADDR_WIDTH  port 1 word address
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read request
s1_write  in  1  port 1 write request
s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes
s1_writedata  in  DATA_WIDTH  port 1 write data
s1_readdata  out  DATA_WIDTH  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid
s1_waitrequest  out  1  port 1 stall
s2_*  (same set of nine signals)  port 2, identical semantics
clear_req  in  1  one-cycle pulse; starts the clear engine
clear_busy  out  1  high while the clear engine runs
oob_err  out  1  sticky; set when either port accesses address >= DEPTH

Behaviour:
- Reset (async assert, sync deassert inside the block): readdata = 0, readdatavalid = 0, clear_busy = 0, oob_err = 0, FSM = IDLE, pipeline emptied. RAM contents are not altered by reset.
- Accept rule: a command is accepted on a port when chipselect & (read|write) & ~waitrequest & clken. read and write asserted together is illegal; the write is performed and the read ignored.
- waitrequest = clear_busy | ~clken. It is combinational, and reset forces it to 0 (FSM in IDLE).
- Read: an accepted read in cycle N gives readdatavalid = 1 with data in cycle N+READ_LATENCY, provided clken stayed high. When clken is low, pipeline stages hold and readdatavalid is held at 0 for those cycles. Back-to-back reads give one result per cycle, in order.
- Write: bytes whose byteenable bit is set are updated at the accepting edge. byteenable = 0 is a legal no-op.
- Cross-port same-address, same cycle:
  - two writes: s1 wins for every byte lane that both ports enable; lanes enabled by only one port take that port's data.
  - one read and one write: the read returns OLD data.
- Out of bounds (address >= DEPTH): writes are dropped, reads return 0 with the normal readdatavalid timing, and oob_err is set. oob_err clears only on reset.
- Clear FSM:
  - IDLE: clear_req -> CLEAR, counter = 0, clear_busy = 1. clear_req while busy is ignored.
  - CLEAR: writes CLEAR_VALUE to address counter each cycle clken = 1, then increments. When counter = DEPTH-1 is written -> DRAIN.
  - DRAIN: one cycle, so that reads already in flight when the clear started complete with pre-clear data -> IDLE, clear_busy = 0.
  - A clear takes DEPTH+1 enabled cycles.
- clear_req in the same cycle as an accepted port command: the command is accepted (waitrequest was still 0), and the clear starts the next cycle.
- reset_n asserted mid-clear: FSM returns to IDLE and the array is left partially cleared (documented behaviour, not an error).

Test Plan:
1. READ_LATENCY=1: s1 writes 0xDEADBEEF to addr 5 with byteenable 0xF, then reads addr 5 -> readdatavalid and 0xDEADBEEF exactly 1 cycle after accept. Repeat with READ_LATENCY=2 -> 2 cycles.
2. Byte lanes: addr 7 = 0x11223344; s2 writes 0xAABBCCDD with byteenable 0x5 -> read returns 0x11BB33DD.
3. Collision: same cycle, s1 writes 0x000000FF (byteenable 0x1) and s2 writes 0xFFFFFF00 (byteenable 0xF) to addr 9 -> read gives 0xFFFFFFFF. Then s1 reads addr 9 while s2 writes 0x12345678 to addr 9 -> s1 gets 0xFFFFFFFF, and a later read gives 0x12345678.
4. Streaming with clken: 4 back-to-back reads on s1 with clken low for 2 cycles in the middle -> 4 in-order valid beats; readdatavalid low during the stall; waitrequest high during the stall.
5. Clear with DEPTH=16, CLEAR_VALUE=0xA5A5A5A5:
   - pulse clear_req -> clear_busy high for 17 cycles, and waitrequest is 1 on both ports for that whole window;
   - afterwards every address reads 0xA5A5A5A5.
   - A read accepted the cycle before clear_req returns its pre-clear value.
6. Out of bounds with DEPTH=16: write 0x1 to addr 20, then read addr 20 -> data 0, oob_err = 1 and held; after reset_n pulse, oob_err = 0.
